// File: rtl/conv_add_tree_acc.sv
// rtl/conv_add_tree_acc.sv - per-lane registered adder tree, group accumulator, bias/saturate/ReLU output stage
module conv_add_tree_acc #(
    parameter int LANES   = 16,
    parameter int TERMS   = 11,
    parameter int IN_W    = 32,
    parameter int ACC_W   = 40,
    parameter int OUT_W   = 32,
    parameter int CNT_W   = 5,
    parameter int POS_W   = 4,
    parameter int RELU_EN = 1
) (
    input  logic                        clk,
    input  logic                        rst_b,
    input  logic                        en,
    input  logic                        in_valid,
    input  logic                        in_first,
    input  logic                        in_last,
    input  logic [LANES*TERMS*IN_W-1:0] in_data,
    input  logic [IN_W-1:0]             in_bias,
    input  logic [CNT_W-1:0]            cnt_in,
    input  logic [POS_W-1:0]            pos_in,
    output logic                        out_valid,
    output logic [LANES*OUT_W-1:0]      out_data,
    output logic [CNT_W-1:0]            cnt_out,
    output logic [POS_W-1:0]            pos_out,
    output logic                        sat_out
);

    localparam int D = ($clog2(TERMS) > 1) ? $clog2(TERMS) : 1;
    localparam logic signed [ACC_W:0] SAT_MAX = {{(ACC_W-OUT_W+2){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [ACC_W:0] SAT_MIN = ~SAT_MAX;

    function automatic int lvl_cnt(input int l);
        int n;
        n = TERMS;
        for (int i = 0; i < l; i++) n = (n + 1) / 2;
        return n;
    endfunction

    function automatic logic signed [ACC_W-1:0] term(input logic [LANES*TERMS*IN_W-1:0] d,
                                                     input int ln, input int t);
        logic signed [IN_W-1:0] x;
        x = d[(LANES*TERMS-1-(ln*TERMS+t))*IN_W +: IN_W];
        return ACC_W'(x);
    endfunction

    logic signed [ACC_W-1:0] r_lvl  [1:D][LANES][TERMS];
    logic signed [ACC_W-1:0] w_next [1:D][LANES][TERMS];
    logic                    r_vs   [1:D];
    logic                    r_fs   [1:D];
    logic                    r_ls   [1:D];
    logic [IN_W-1:0]         r_bs   [1:D];
    logic [CNT_W-1:0]        r_cs   [1:D];
    logic [POS_W-1:0]        r_ps   [1:D];

    logic signed [ACC_W-1:0] r_acc [LANES];
    logic                    r_a_last;
    logic signed [IN_W-1:0]  r_a_bias;
    logic [CNT_W-1:0]        r_a_cnt;
    logic [POS_W-1:0]        r_a_pos;

    logic [LANES*OUT_W-1:0]  w_res;
    logic                    w_sat;

    // Level l node t sums nodes 2t and 2t+1 of level l-1; an unpaired last node passes through.
    always_comb begin : tree_comb
        int n_prev;
        int i_a;
        int i_b;
        logic signed [ACC_W-1:0] w_a;
        logic signed [ACC_W-1:0] w_b;
        n_prev = TERMS;
        i_a = 0;
        i_b = 0;
        w_a = '0;
        w_b = '0;
        for (int l = 1; l <= D; l++)
            for (int ln = 0; ln < LANES; ln++)
                for (int t = 0; t < TERMS; t++)
                    w_next[l][ln][t] = '0;
        for (int l = 1; l <= D; l++) begin
            n_prev = lvl_cnt(l - 1);
            for (int ln = 0; ln < LANES; ln++) begin
                for (int t = 0; t < (TERMS + 1) / 2; t++) begin
                    i_a = 2 * t;
                    i_b = (2 * t + 1 < TERMS) ? 2 * t + 1 : 0;
                    w_a = '0;
                    w_b = '0;
                    if (i_a < n_prev) begin
                        if (l == 1) begin
                            w_a = term(in_data, ln, i_a);
                            if (2 * t + 1 < n_prev) w_b = term(in_data, ln, i_b);
                        end else begin
                            w_a = r_lvl[(l > 1) ? l - 1 : 1][ln][i_a];
                            if (2 * t + 1 < n_prev) w_b = r_lvl[(l > 1) ? l - 1 : 1][ln][i_b];
                        end
                        w_next[l][ln][t] = w_a + w_b;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            for (int l = 1; l <= D; l++) begin
                for (int ln = 0; ln < LANES; ln++)
                    for (int t = 0; t < TERMS; t++)
                        r_lvl[l][ln][t] <= '0;
                r_vs[l] <= 1'b0;
                r_fs[l] <= 1'b0;
                r_ls[l] <= 1'b0;
                r_bs[l] <= '0;
                r_cs[l] <= '0;
                r_ps[l] <= '0;
            end
        end else if (en) begin
            r_lvl <= w_next;
            r_vs[1] <= in_valid;
            r_fs[1] <= in_first;
            r_ls[1] <= in_last;
            r_bs[1] <= in_bias;
            r_cs[1] <= cnt_in;
            r_ps[1] <= pos_in;
            for (int l = 2; l <= D; l++) begin
                r_vs[l] <= r_vs[l-1];
                r_fs[l] <= r_fs[l-1];
                r_ls[l] <= r_ls[l-1];
                r_bs[l] <= r_bs[l-1];
                r_cs[l] <= r_cs[l-1];
                r_ps[l] <= r_ps[l-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            for (int ln = 0; ln < LANES; ln++) r_acc[ln] <= '0;
            r_a_last <= 1'b0;
            r_a_bias <= '0;
            r_a_cnt  <= '0;
            r_a_pos  <= '0;
        end else if (en) begin
            if (r_vs[D]) begin
                for (int ln = 0; ln < LANES; ln++)
                    r_acc[ln] <= r_fs[D] ? r_lvl[D][ln][0] : r_acc[ln] + r_lvl[D][ln][0];
            end
            r_a_last <= r_vs[D] & r_ls[D];
            r_a_bias <= r_bs[D];
            r_a_cnt  <= r_cs[D];
            r_a_pos  <= r_ps[D];
        end
    end

    // One extra bit keeps acc + bias exact before clamping to the output range.
    always_comb begin : out_comb
        logic signed [ACC_W:0]   w_v;
        logic signed [OUT_W-1:0] w_r;
        w_res = '0;
        w_sat = 1'b0;
        w_v   = '0;
        w_r   = '0;
        for (int ln = 0; ln < LANES; ln++) begin
            w_v = (ACC_W+1)'(r_acc[ln]) + (ACC_W+1)'(r_a_bias);
            if (w_v > SAT_MAX) begin
                w_r   = SAT_MAX[OUT_W-1:0];
                w_sat = 1'b1;
            end else if (w_v < SAT_MIN) begin
                w_r   = SAT_MIN[OUT_W-1:0];
                w_sat = 1'b1;
            end else begin
                w_r = w_v[OUT_W-1:0];
            end
            if (RELU_EN == 1 && w_r[OUT_W-1]) w_r = '0;
            w_res[(LANES-1-ln)*OUT_W +: OUT_W] = w_r;
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            cnt_out   <= '0;
            pos_out   <= '0;
            sat_out   <= 1'b0;
        end else if (en) begin
            out_valid <= r_a_last;
            sat_out   <= r_a_last & w_sat;
            if (r_a_last) begin
                out_data <= w_res;
                cnt_out  <= r_a_cnt;
                pos_out  <= r_a_pos;
            end
        end
    end

endmodule

// File: tb/tb_conv_add_tree_acc.sv
// tb/tb_conv_add_tree_acc.sv - directed self-checking bench for conv_add_tree_acc
module tb_conv_add_tree_acc;

    localparam int LANES = 16;
    localparam int TERMS = 11;
    localparam int IN_W  = 32;
    localparam int OUT_W = 32;

    logic                        clk = 1'b0;
    logic                        rst_b;
    logic                        en;
    logic                        in_valid;
    logic                        in_first;
    logic                        in_last;
    logic [LANES*TERMS*IN_W-1:0] in_data;
    logic [IN_W-1:0]             in_bias;
    logic [4:0]                  cnt_in;
    logic [3:0]                  pos_in;

    logic                        out_valid, nr_valid;
    logic [LANES*OUT_W-1:0]      out_data, nr_data;
    logic [4:0]                  cnt_out, nr_cnt;
    logic [3:0]                  pos_out, nr_pos;
    logic                        sat_out, nr_sat;

    int checks   = 0;
    int failures = 0;

    conv_add_tree_acc #(.RELU_EN(1)) u_dut (
        .clk(clk), .rst_b(rst_b), .en(en), .in_valid(in_valid), .in_first(in_first),
        .in_last(in_last), .in_data(in_data), .in_bias(in_bias), .cnt_in(cnt_in),
        .pos_in(pos_in), .out_valid(out_valid), .out_data(out_data), .cnt_out(cnt_out),
        .pos_out(pos_out), .sat_out(sat_out)
    );

    conv_add_tree_acc #(.RELU_EN(0)) u_dut_nr (
        .clk(clk), .rst_b(rst_b), .en(en), .in_valid(in_valid), .in_first(in_first),
        .in_last(in_last), .in_data(in_data), .in_bias(in_bias), .cnt_in(cnt_in),
        .pos_in(pos_in), .out_valid(nr_valid), .out_data(nr_data), .cnt_out(nr_cnt),
        .pos_out(nr_pos), .sat_out(nr_sat)
    );

    always #5 clk = ~clk;

    function automatic logic [OUT_W-1:0] lane(input logic [LANES*OUT_W-1:0] d, input int j);
        return d[(LANES-1-j)*OUT_W +: OUT_W];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_terms(input logic [IN_W-1:0] v);
        for (int ln = 0; ln < LANES; ln++)
            for (int t = 0; t < TERMS; t++)
                in_data[(LANES*TERMS-1-(ln*TERMS+t))*IN_W +: IN_W] = v;
    endtask

    task automatic run_single(input logic [IN_W-1:0] v, input logic [IN_W-1:0] b,
                              input logic [4:0] c, input logic [3:0] p, output int lat);
        set_terms(v);
        in_bias = b; cnt_in = c; pos_in = p;
        in_valid = 1'b1; in_first = 1'b1; in_last = 1'b1;
        tick();
        lat = 1;
        in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
        while (out_valid !== 1'b1 && lat < 20) begin
            tick();
            lat++;
        end
    endtask

    task automatic test_reset();
        rst_b = 1'b0; en = 1'b1; in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
        in_data = '0; in_bias = '0; cnt_in = '0; pos_in = '0;
        repeat (3) tick();
        rst_b = 1'b1;
        tick();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0b exp=0", out_valid); end
        checks++; if (out_data !== '0) begin failures++; $display("FAIL reset_data got=%h exp=0", out_data); end
        checks++; if (cnt_out !== 5'd0 || pos_out !== 4'd0) begin failures++; $display("FAIL reset_tags got=%0d/%0d exp=0/0", cnt_out, pos_out); end
        checks++; if (sat_out !== 1'b0) begin failures++; $display("FAIL reset_sat got=%0b exp=0", sat_out); end
    endtask

    task automatic test_single_beat();
        int lat;
        for (int ln = 0; ln < LANES; ln++)
            for (int t = 0; t < TERMS; t++)
                in_data[(LANES*TERMS-1-(ln*TERMS+t))*IN_W +: IN_W] = IN_W'(ln + 1);
        in_bias = 32'd5; cnt_in = 5'd7; pos_in = 4'd3;
        in_valid = 1'b1; in_first = 1'b1; in_last = 1'b1;
        tick();
        lat = 1;
        in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
        while (out_valid !== 1'b1 && lat < 20) begin tick(); lat++; end
        checks++; if (lat != 6) begin failures++; $display("FAIL single_latency got=%0d exp=6", lat); end
        for (int j = 0; j < LANES; j++) begin
            checks++;
            if (lane(out_data, j) !== 32'(11 * (j + 1) + 5)) begin
                failures++; $display("FAIL single_lane%0d got=%0d exp=%0d", j, lane(out_data, j), 11 * (j + 1) + 5);
            end
        end
        checks++; if (cnt_out !== 5'd7 || pos_out !== 4'd3) begin failures++; $display("FAIL single_tags got=%0d/%0d exp=7/3", cnt_out, pos_out); end
        checks++; if (sat_out !== 1'b0) begin failures++; $display("FAIL single_sat got=%0b exp=0", sat_out); end
        tick();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL single_pulse_width got=%0b exp=0", out_valid); end
    endtask

    task automatic test_async_reset();
        int seen;
        set_terms(32'd4);
        in_valid = 1'b1; in_first = 1'b1; in_last = 1'b0;
        tick();
        in_first = 1'b0;
        #3;
        rst_b = 1'b0;
        #1;
        checks++; if (out_data !== '0) begin failures++; $display("FAIL async_reset_data got=%h exp=0", out_data); end
        checks++; if (out_valid !== 1'b0 || cnt_out !== 5'd0 || pos_out !== 4'd0) begin
            failures++; $display("FAIL async_reset_ctrl got=%0b/%0d/%0d exp=0/0/0", out_valid, cnt_out, pos_out);
        end
        #2;
        rst_b = 1'b1;
        in_first = 1'b1;
        seen = 0;
        repeat (8) begin
            tick();
            in_first = 1'b0;
            if (out_valid === 1'b1) seen++;
        end
        in_valid = 1'b0;
        checks++; if (seen != 0) begin failures++; $display("FAIL post_reset_no_output got=%0d exp=0", seen); end
    endtask

    task automatic test_accumulate();
        int lat;
        set_terms(32'd2); in_bias = '0; cnt_in = 5'd1; pos_in = 4'd1;
        in_valid = 1'b1; in_first = 1'b1; in_last = 1'b0;
        tick();
        in_first = 1'b0;
        tick();
        in_last = 1'b1;
        tick();
        lat = 1;
        set_terms(32'd1); in_first = 1'b1; in_last = 1'b1;
        tick();
        lat = 2;
        in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
        while (out_valid !== 1'b1 && lat < 20) begin tick(); lat++; end
        checks++; if (lat != 6) begin failures++; $display("FAIL acc_latency got=%0d exp=6", lat); end
        for (int j = 0; j < LANES; j++) begin
            checks++;
            if (lane(out_data, j) !== 32'd66) begin failures++; $display("FAIL acc_lane%0d got=%0d exp=66", j, lane(out_data, j)); end
        end
        tick();
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL b2b_valid got=%0b exp=1", out_valid); end
        for (int j = 0; j < LANES; j++) begin
            checks++;
            if (lane(out_data, j) !== 32'd11) begin failures++; $display("FAIL b2b_lane%0d got=%0d exp=11", j, lane(out_data, j)); end
        end
        tick();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL b2b_end got=%0b exp=0", out_valid); end
    endtask

    task automatic test_relu_sign();
        int lat;
        run_single(-32'sd10, 32'd3, 5'd2, 4'd2, lat);
        checks++; if (lat != 6 || nr_valid !== 1'b1) begin failures++; $display("FAIL relu_latency got=%0d/%0b exp=6/1", lat, nr_valid); end
        for (int j = 0; j < LANES; j++) begin
            checks++;
            if (lane(out_data, j) !== 32'd0) begin failures++; $display("FAIL relu_lane%0d got=%0d exp=0", j, lane(out_data, j)); end
            checks++;
            if (lane(nr_data, j) !== -32'sd107) begin failures++; $display("FAIL norelu_lane%0d got=%0d exp=-107", j, $signed(lane(nr_data, j))); end
        end
        checks++; if (sat_out !== 1'b0 || nr_sat !== 1'b0) begin failures++; $display("FAIL relu_sat got=%0b/%0b exp=0/0", sat_out, nr_sat); end
    endtask

    task automatic test_saturation();
        int lat;
        run_single(32'h7FFF_FFFF, 32'd0, 5'd3, 4'd4, lat);
        checks++; if (lat != 6) begin failures++; $display("FAIL satpos_latency got=%0d exp=6", lat); end
        for (int j = 0; j < LANES; j++) begin
            checks++;
            if (lane(out_data, j) !== 32'h7FFF_FFFF || lane(nr_data, j) !== 32'h7FFF_FFFF) begin
                failures++; $display("FAIL satpos_lane%0d got=%h/%h exp=7fffffff", j, lane(out_data, j), lane(nr_data, j));
            end
        end
        checks++; if (sat_out !== 1'b1 || nr_sat !== 1'b1) begin failures++; $display("FAIL satpos_flag got=%0b/%0b exp=1/1", sat_out, nr_sat); end
        run_single(32'h8000_0000, 32'd0, 5'd4, 4'd5, lat);
        checks++; if (lat != 6) begin failures++; $display("FAIL satneg_latency got=%0d exp=6", lat); end
        for (int j = 0; j < LANES; j++) begin
            checks++;
            if (lane(nr_data, j) !== 32'h8000_0000 || lane(out_data, j) !== 32'd0) begin
                failures++; $display("FAIL satneg_lane%0d got=%h/%h exp=80000000/0", j, lane(nr_data, j), lane(out_data, j));
            end
        end
        checks++; if (nr_sat !== 1'b1 || sat_out !== 1'b1) begin failures++; $display("FAIL satneg_flag got=%0b/%0b exp=1/1", nr_sat, sat_out); end
    endtask

    task automatic test_stall();
        int lat;
        set_terms(32'd3); in_bias = 32'd1; cnt_in = 5'd9; pos_in = 4'd2;
        in_valid = 1'b1; in_first = 1'b1; in_last = 1'b1;
        tick();
        lat = 1;
        in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
        tick();
        lat = 2;
        en = 1'b0;
        repeat (3) tick();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL stall_early got=%0b exp=0", out_valid); end
        en = 1'b1;
        while (out_valid !== 1'b1 && lat < 20) begin tick(); lat++; end
        checks++; if (lat != 6) begin failures++; $display("FAIL stall_latency got=%0d exp=6", lat); end
        for (int j = 0; j < LANES; j++) begin
            checks++;
            if (lane(out_data, j) !== 32'd34) begin failures++; $display("FAIL stall_lane%0d got=%0d exp=34", j, lane(out_data, j)); end
        end
        checks++; if (cnt_out !== 5'd9 || pos_out !== 4'd2) begin failures++; $display("FAIL stall_tags got=%0d/%0d exp=9/2", cnt_out, pos_out); end
        en = 1'b0;
        tick();
        checks++; if (out_valid !== 1'b1 || lane(out_data, 0) !== 32'd34) begin
            failures++; $display("FAIL stall_hold got=%0b/%0d exp=1/34", out_valid, lane(out_data, 0));
        end
        en = 1'b1;
        tick();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL stall_pulse_end got=%0b exp=0", out_valid); end
        checks++; if (lane(out_data, 0) !== 32'd34) begin failures++; $display("FAIL stall_data_hold got=%0d exp=34", lane(out_data, 0)); end
    endtask

    task automatic test_reset_mid_group();
        int lat;
        set_terms(32'd5); in_bias = '0;
        in_valid = 1'b1; in_first = 1'b1; in_last = 1'b0;
        tick();
        in_valid = 1'b0; in_first = 1'b0;
        tick();
        #2;
        rst_b = 1'b0;
        #2;
        rst_b = 1'b1;
        tick();
        run_single(32'd1, 32'd0, 5'd11, 4'd6, lat);
        checks++; if (lat != 6) begin failures++; $display("FAIL midreset_latency got=%0d exp=6", lat); end
        for (int j = 0; j < LANES; j++) begin
            checks++;
            if (lane(out_data, j) !== 32'd11) begin failures++; $display("FAIL midreset_lane%0d got=%0d exp=11", j, lane(out_data, j)); end
        end
        checks++; if (cnt_out !== 5'd11 || pos_out !== 4'd6) begin failures++; $display("FAIL midreset_tags got=%0d/%0d exp=11/6", cnt_out, pos_out); end
    endtask

    initial begin
        test_reset();
        test_single_beat();
        test_async_reset();
        test_accumulate();
        test_relu_sign();
        test_saturation();
        test_stall();
        test_reset_mid_group();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/conv_add_tree_acc.md
Name: conv_add_tree_acc

Overview:
- Parametrised successor of the second-stage convolution adder.
- Each of LANES output lanes reduces TERMS signed partial products through a registered adder tree.
- Partial sums accumulate over a multi-beat input-channel group (in_first … in_last). At group end the block adds the bias, saturates, optionally applies ReLU, and emits one valid beat.
- cnt/pos sideband tags travel with each group and are aligned to the output beat.

Parameters:
- LANES, 16, number of independent output lanes.
- TERMS, 11, partial products summed per lane per beat (≥1).
- IN_W, 32, signed width of each term and of the bias.
- ACC_W, 40, signed accumulator width (≥ IN_W + clog2(TERMS)).
- OUT_W, 32, signed output width (≤ ACC_W).
- CNT_W, 5, cnt tag width.
- POS_W, 4, pos tag width.
- RELU_EN, 1, 1 = clamp negative outputs to 0.

Ports:
- clk  in  1  clock, rising edge.
- rst_b  in  1  asynchronous active-low reset.
- en  in  1  global advance; 0 freezes every register.
- in_valid  in  1  input beat present.
- in_first  in  1  first beat of a group; restarts accumulation.
- in_last  in  1  last beat of a group; triggers output.
- in_data  in  LANES*TERMS*IN_W  lane-major terms, lane 0 / term 0 in the MSBs.
- in_bias  in  IN_W  signed bias, sampled with the in_last beat.
- cnt_in  in  CNT_W  tag, sampled with the in_last beat.
- pos_in  in  POS_W  tag, sampled with the in_last beat.
- out_valid  out  1  one-cycle result pulse.
- out_data  out  LANES*OUT_W  lane-major results.
- cnt_out  out  CNT_W  tag of the emitted group.
- pos_out  out  POS_W  tag of the emitted group.
- sat_out  out  1  high with out_valid if any lane saturated.

Behaviour:
- Reset (rst_b=0, async): all pipeline, accumulator and output registers go to 0. out_valid=0, out_data=0, cnt_out=0, pos_out=0, sat_out=0. Partial groups are discarded.
- A beat is accepted on a rising edge where en=1 and in_valid=1. One beat per cycle; no backpressure.
- Adder tree: D = max(1, clog2(TERMS)) registered levels. Pairwise sums are sign-extended to ACC_W; an odd leftover passes through its level. Level 1 captures on the sampling edge E0.
- Valid, first, last, bias and tags shift alongside the tree levels.
- Accumulator stage (edge E0+D), per lane:
  - first=1: acc = tree_sum.
  - first=0: acc = acc + tree_sum, wrapping mod 2^ACC_W.
  - A non-first beat with no prior first adds to the current acc (0 after reset).
  - Non-valid slots leave acc unchanged.
- Output stage (edge E0+D+1), only for a valid last beat:
  - v = acc + sext(bias).
  - Saturate v to the signed OUT_W range; set sat_out if any lane clipped.
  - If RELU_EN=1 and the result is negative, output 0.
  - Register out_data, cnt_out, pos_out, sat_out; out_valid=1 for exactly one enabled cycle.
- Latency: D+2 rising edges, counting the sampling edge. With TERMS=11 that is 6.
- first=last=1: single-beat group.
- A new group's first beat may immediately follow last. The output stage captures the old acc on the same edge the new first overwrites it; no bubble is required.
- en=0: all state holds, including out_valid. A held out_valid=1 is not re-counted: the pulse ends on the first enabled edge without a new result.
- Outside valid pulses, out_data, cnt_out and pos_out hold their last values.
- Reset mid-group: group lost; no output is produced for it.

Test Plan:
- Reset: drive rst_b=0 mid-traffic → all outputs 0 immediately (asynchronous). After release, out_valid stays 0 until a last beat has passed.
- Single beat: lane j terms all = j+1, bias=5, first=last=1, cnt_in=7, pos_in=3, en=1 → after 6 edges out_valid=1 for one cycle, lane j = 11*(j+1)+5 (lane 15 = 181), cnt_out=7, pos_out=3, sat_out=0.
- Accumulate: three back-to-back beats (first, middle, last), all terms=2, bias=0 → one out_valid, every lane = 66. A following first=last beat (terms=1) yields 11 on the very next cycle.
- Sign/ReLU: all terms=-10, bias=3 → RELU_EN=1 gives 0 on all lanes; RELU_EN=0 gives -107.
- Saturation: all terms=0x7FFFFFFF → every lane = 0x7FFFFFFF, sat_out=1. All terms=0x80000000 with RELU_EN=0 → 0x80000000, sat_out=1.
- Stall/reset: en=0 for 3 cycles mid-pipeline → out_valid 3 cycles later, values unchanged. Reset between first and last, then one first=last beat → clean single-beat result.
